pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Stall/flush/halt controller for the 5-stage RISC-V pipeline, the counterpart to the EX-stage forwarding logic. It resolves the hazards forwarding cannot: load-use (stall and bubble), taken branches (flush), and HALT (drain and freeze). It also gates the whole pipeline for debug single-step. It sits beside the IF/ID and ID/EX registers and drives their write enables, bubble inputs and flush inputs, plus the PC write enable.

## Interface
- DRAIN_CYCLES, 3: cycles spent draining older instructions after HALT before freezing.
- CNT_W, 16: width of the stall performance counter.

- i_clk  in  1  rising-edge clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_ID_EX_mem_read  in  1  instruction in EX is a load.
- i_ID_EX_rd  in  5  destination register of the instruction in EX.
- i_IF_ID_rs1, i_IF_ID_rs2  in  5 each  source registers of the instruction in ID.
- i_IF_ID_uses_rs1, i_IF_ID_uses_rs2  in  1 each  the instruction in ID actually reads that source.
- i_EX_branch_taken  in  1  branch or jump resolved taken in EX this cycle.
- i_halt_decoded  in  1  the instruction in ID is HALT.
- i_step_mode  in  1  debug single-step mode enabled.
- i_step  in  1  single-cycle pulse: advance one cycle while in step mode.
- o_pc_write  out  1  PC load enable.
- o_IF_ID_write  out  1  IF/ID register write enable.
- o_IF_ID_flush  out  1  IF/ID register loads a NOP.
- o_ID_EX_bubble  out  1  ID/EX register loads a NOP (control bits cleared).
- o_pipe_en  out  1  write enable for the ID/EX, EX/MEM and MEM/WB registers.
- o_halted  out  1  the pipeline is frozen after HALT.
- o_state  out  2  current FSM state, for the debug unit.
- o_stall_count  out  CNT_W  number of load-use stall cycles taken; saturates.

## Operation
- `advance` = !i_step_mode || i_step.
  - When `advance` = 0, all enables, flush and bubble are 0.
  - State and counters hold.
- `load_use` = i_ID_EX_mem_read && i_ID_EX_rd != 0 && ((i_IF_ID_uses_rs1 && i_ID_EX_rd == i_IF_ID_rs1) || (i_IF_ID_uses_rs2 && i_ID_EX_rd == i_IF_ID_rs2)).
- FSM states:
  - RUN = 0
  - DRAIN = 1
  - HALTED = 2
- RUN with `advance`, evaluated in priority order:
  1. i_EX_branch_taken: pc_write = 1, IF_ID_flush = 1, ID_EX_bubble = 1, pipe_en = 1. Branch beats load-use and halt, because the ID instruction is on the wrong path.
  2. i_halt_decoded: pc_write = 0, IF_ID_write = 0, ID_EX_bubble = 1, pipe_en = 1. Next state is DRAIN and drain_cnt is loaded with DRAIN_CYCLES. Halt beats load-use.
  3. load_use: pc_write = 0, IF_ID_write = 0, ID_EX_bubble = 1, pipe_en = 1. o_stall_count increments by 1, saturating at all-ones.
  4. Otherwise: pc_write = 1, IF_ID_write = 1, pipe_en = 1, flush = 0, bubble = 0.
- DRAIN with `advance`:
  - Outputs: pc_write = 0, IF_ID_write = 0, ID_EX_bubble = 1, pipe_en = 1.
  - drain_cnt decrements; when drain_cnt == 1, next state is HALTED.
  - Branch, halt and load-use inputs are ignored.
- HALTED:
  - All enables, flush and bubble are 0; o_halted = 1.
  - Only i_reset leaves this state; i_step and i_step_mode have no effect.
- While i_reset is high, all outputs are 0, including o_pipe_en, o_halted and o_stall_count. The next state is RUN with drain_cnt = 0.

## Timing
- Enable, flush and bubble outputs are Mealy combinational outputs from state and current inputs, so a stall takes effect in the same cycle the hazard is present.
- State, drain_cnt and o_stall_count update on the rising clock edge.
- o_halted and o_state are decoded from registered state.
- A load-use stall lasts exactly 1 cycle: after the bubble, the load sits in MEM and the forwarding logic supplies the operand.
- Halt latency: HALT in ID at cycle t (with `advance`) gives DRAIN at t+1 through t+DRAIN_CYCLES, and o_halted = 1 from cycle t+DRAIN_CYCLES+1.
- In step mode, each i_step pulse counts as exactly one cycle. A held i_step advances on every cycle it is high.
- Reset in any state, including mid-DRAIN, returns to RUN on the next edge. The counter clears.
- drain_cnt width is clog2(DRAIN_CYCLES+1). DRAIN_CYCLES must be at least 1.

## Structure
- Shared package `pipeline_pkg`:
  - state enum: RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2;
  - the DRAIN_CYCLES default constant.
- One sub-module, `sat_counter`:
  - width-parameterised;
  - inputs: synchronous clear, increment enable;
  - holds at all-ones;
  - used for o_stall_count.

## Test plan
- Load x5 in EX; ID reads rs1 = 5 with uses_rs1 = 1 → one cycle of pc_write = 0, IF_ID_write = 0, bubble = 1, and stall_count goes 0 → 1. With rd = 0, or uses_rs1 = 0, there is no stall.
- load_use and i_EX_branch_taken in the same cycle → flush = 1, bubble = 1, pc_write = 1, and stall_count is unchanged.
- i_halt_decoded at cycle t (DRAIN_CYCLES = 3) → o_state = 1 for t+1 through t+3, o_halted = 1 at t+4. Afterwards, branch/step inputs cause no enable activity.
- i_step_mode = 1 with no i_step for 10 cycles → all enables 0 and state held. A single i_step pulse gives exactly one cycle of RUN outputs.
- Force 2^16 + 5 load-use stall cycles → o_stall_count = 16'hFFFF.
- i_reset asserted mid-DRAIN → next cycle o_state = 0, all outputs 0 during reset, and normal RUN outputs once reset is released.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Purpose: shared types and defaults for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_pkg;

    // Controller FSM encoding; the debug unit reads it through o_state.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose: bundle of hazard inputs and pipeline control outputs for the hazard controller.
// Latency: n/a (wires only).
// Backpressure: n/a; the controller itself gates the pipeline.
// Ports: master = pipeline/datapath side (drives hazard info, receives enables),
//        slave  = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             i_ID_EX_mem_read;
    logic [4:0]       i_ID_EX_rd;
    logic [4:0]       i_IF_ID_rs1;
    logic [4:0]       i_IF_ID_rs2;
    logic             i_IF_ID_uses_rs1;
    logic             i_IF_ID_uses_rs2;
    logic             i_EX_branch_taken;
    logic             i_halt_decoded;
    logic             i_step_mode;
    logic             i_step;

    logic             o_pc_write;
    logic             o_IF_ID_write;
    logic             o_IF_ID_flush;
    logic             o_ID_EX_bubble;
    logic             o_pipe_en;
    logic             o_halted;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_stall_count;

    modport master (
        output i_ID_EX_mem_read, i_ID_EX_rd, i_IF_ID_rs1, i_IF_ID_rs2,
               i_IF_ID_uses_rs1, i_IF_ID_uses_rs2, i_EX_branch_taken,
               i_halt_decoded, i_step_mode, i_step,
        input  o_pc_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_bubble,
               o_pipe_en, o_halted, o_state, o_stall_count
    );

    modport slave (
        input  i_ID_EX_mem_read, i_ID_EX_rd, i_IF_ID_rs1, i_IF_ID_rs2,
               i_IF_ID_uses_rs1, i_IF_ID_uses_rs2, i_EX_branch_taken,
               i_halt_decoded, i_step_mode, i_step,
        output o_pc_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_bubble,
               o_pipe_en, o_halted, o_state, o_stall_count
    );
endinterface

// File: rtl/sat_counter.sv
// Purpose: width-parameterised up-counter that sticks at all-ones.
// Latency: count updates one clock after inc; clr wins over inc.
// Backpressure: none; inc is ignored once saturated.
// Ports: clk, clr (synchronous clear), inc (increment enable), count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush/halt/single-step controller for the 5-stage pipeline.
// Latency: enables are combinational from state + inputs (same-cycle stall); state/counter update on clock.
// Backpressure: freezes the whole pipeline when step mode is on without a step pulse, or once halted.
// Ports: i_clk, i_reset (sync, active-high), hz (slave side of pipeline_hazard_ctrl_if).
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_e           state;
    logic [DW-1:0]    drain_cnt;
    logic             advance;
    logic             load_use;
    logic             stall_inc;
    logic [CNT_W-1:0] stall_cnt;

    assign advance  = !hz.i_step_mode || hz.i_step;

    // x0 is never a real producer, so a load to x0 cannot create a hazard.
    assign load_use = hz.i_ID_EX_mem_read && (hz.i_ID_EX_rd != 5'd0) &&
                      ((hz.i_IF_ID_uses_rs1 && (hz.i_ID_EX_rd == hz.i_IF_ID_rs1)) ||
                       (hz.i_IF_ID_uses_rs2 && (hz.i_ID_EX_rd == hz.i_IF_ID_rs2)));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else if (advance) begin
            case (state)
                RUN: begin
                    // A taken branch squashes the HALT sitting in ID.
                    if (!hz.i_EX_branch_taken && hz.i_halt_decoded) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - DW'(1);
                    if (drain_cnt == DW'(1)) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        hz.o_pc_write     = 1'b0;
        hz.o_IF_ID_write  = 1'b0;
        hz.o_IF_ID_flush  = 1'b0;
        hz.o_ID_EX_bubble = 1'b0;
        hz.o_pipe_en      = 1'b0;
        if (!i_reset && advance) begin
            case (state)
                RUN: begin
                    hz.o_pipe_en = 1'b1;
                    if (hz.i_EX_branch_taken) begin
                        // IF/ID is written so that the flush NOP actually lands.
                        hz.o_pc_write     = 1'b1;
                        hz.o_IF_ID_write  = 1'b1;
                        hz.o_IF_ID_flush  = 1'b1;
                        hz.o_ID_EX_bubble = 1'b1;
                    end else if (hz.i_halt_decoded || load_use) begin
                        hz.o_ID_EX_bubble = 1'b1;
                    end else begin
                        hz.o_pc_write    = 1'b1;
                        hz.o_IF_ID_write = 1'b1;
                    end
                end
                DRAIN: begin
                    hz.o_pipe_en      = 1'b1;
                    hz.o_ID_EX_bubble = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Only genuine load-use stalls count; branch and halt win over them.
    assign stall_inc = !i_reset && advance && (state == RUN) &&
                       !hz.i_EX_branch_taken && !hz.i_halt_decoded && load_use;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .clr   (i_reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    // Observable outputs read as zero for the whole reset window, not just after the edge.
    assign hz.o_stall_count = i_reset ? '0 : stall_cnt;
    assign hz.o_halted      = !i_reset && (state == HALTED);
    assign hz.o_state       = i_reset ? 2'd0 : state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: directed self-checking bench for pipeline_hazard_ctrl.
// Latency: inputs driven 1 ns after posedge, outputs sampled 1 ns later.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) hz ();

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .hz      (hz.slave)
    );

    always #5 clk = ~clk;

    // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_en}
    localparam logic [4:0] E_RUN   = 5'b11001;
    localparam logic [4:0] E_STALL = 5'b00011;
    localparam logic [4:0] E_OFF   = 5'b00000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ena();
        return {hz.o_pc_write, hz.o_IF_ID_write, hz.o_IF_ID_flush,
                hz.o_ID_EX_bubble, hz.o_pipe_en};
    endfunction

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.i_ID_EX_mem_read  = 1'b0;
        hz.i_ID_EX_rd        = 5'd0;
        hz.i_IF_ID_rs1       = 5'd0;
        hz.i_IF_ID_rs2       = 5'd0;
        hz.i_IF_ID_uses_rs1  = 1'b0;
        hz.i_IF_ID_uses_rs2  = 1'b0;
        hz.i_EX_branch_taken = 1'b0;
        hz.i_halt_decoded    = 1'b0;
        hz.i_step_mode       = 1'b0;
        hz.i_step            = 1'b0;
    endtask

    // Load writing x5 in EX; ID reads x5 via rs1.
    task automatic set_load_use();
        hz.i_ID_EX_mem_read = 1'b1;
        hz.i_ID_EX_rd       = 5'd5;
        hz.i_IF_ID_rs1      = 5'd5;
        hz.i_IF_ID_uses_rs1 = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        set_load_use();
        hz.i_EX_branch_taken = 1'b1;
        #1;
        chk("reset_ena", 32'(ena()), 32'(E_OFF));
        tick();
        chk("reset_state", 32'(hz.o_state), 32'd0);
        chk("reset_halted", 32'(hz.o_halted), 32'd0);
        chk("reset_cnt", 32'(hz.o_stall_count), 32'd0);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("run_ena", 32'(ena()), 32'(E_RUN));

        // Basic load-use via rs1.
        tick();
        set_load_use();
        #1;
        chk("lu_ena", 32'(ena()), 32'(E_STALL));
        tick();
        chk("lu_cnt", 32'(hz.o_stall_count), 32'd1);
        idle_inputs();
        #1;
        chk("lu_after", 32'(ena()), 32'(E_RUN));

        // rd = x0: no hazard.
        set_load_use();
        hz.i_ID_EX_rd  = 5'd0;
        hz.i_IF_ID_rs1 = 5'd0;
        #1;
        chk("rd0_ena", 32'(ena()), 32'(E_RUN));
        // rs1 matches but is not used.
        set_load_use();
        hz.i_IF_ID_uses_rs1 = 1'b0;
        #1;
        chk("nouse_ena", 32'(ena()), 32'(E_RUN));
        tick();
        chk("nouse_cnt", 32'(hz.o_stall_count), 32'd1);
        // Hazard through rs2.
        hz.i_IF_ID_rs2      = 5'd5;
        hz.i_IF_ID_uses_rs2 = 1'b1;
        #1;
        chk("rs2_ena", 32'(ena()), 32'(E_STALL));
        tick();
        chk("rs2_cnt", 32'(hz.o_stall_count), 32'd2);

        // Branch beats load-use.
        set_load_use();
        hz.i_EX_branch_taken = 1'b1;
        #1;
        chk("br_pc", 32'(hz.o_pc_write), 32'd1);
        chk("br_flush", 32'(hz.o_IF_ID_flush), 32'd1);
        chk("br_bubble", 32'(hz.o_ID_EX_bubble), 32'd1);
        chk("br_pipe", 32'(hz.o_pipe_en), 32'd1);
        tick();
        chk("br_cnt", 32'(hz.o_stall_count), 32'd2);

        // Step mode with no step: frozen, counter holds despite a hazard.
        idle_inputs();
        hz.i_step_mode = 1'b1;
        set_load_use();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("step_idle_ena", 32'(ena()), 32'(E_OFF));
            tick();
        end
        chk("step_idle_state", 32'(hz.o_state), 32'd0);
        chk("step_idle_cnt", 32'(hz.o_stall_count), 32'd2);
        // One step pulse = one RUN cycle.
        idle_inputs();
        hz.i_step_mode = 1'b1;
        hz.i_step      = 1'b1;
        #1;
        chk("step_pulse_ena", 32'(ena()), 32'(E_RUN));
        tick();
        hz.i_step = 1'b0;
        #1;
        chk("step_after_ena", 32'(ena()), 32'(E_OFF));

        // Halt at cycle t, drain three cycles, then frozen.
        idle_inputs();
        hz.i_halt_decoded = 1'b1;
        set_load_use();
        #1;
        chk("halt_ena", 32'(ena()), 32'(E_STALL));
        tick();
        idle_inputs();
        hz.i_EX_branch_taken = 1'b1;
        hz.i_halt_decoded    = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("drain_state", 32'(hz.o_state), 32'd1);
            chk("drain_ena", 32'(ena()), 32'(E_STALL));
            chk("drain_halted", 32'(hz.o_halted), 32'd0);
            tick();
        end
        chk("halted_state", 32'(hz.o_state), 32'd2);
        chk("halted_flag", 32'(hz.o_halted), 32'd1);
        chk("halted_ena", 32'(ena()), 32'(E_OFF));
        hz.i_step_mode = 1'b1;
        hz.i_step      = 1'b1;
        tick();
        chk("halted_step_ena", 32'(ena()), 32'(E_OFF));
        chk("halted_hold", 32'(hz.o_state), 32'd2);
        chk("halted_cnt", 32'(hz.o_stall_count), 32'd2);

        // Reset mid-DRAIN.
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hz.i_halt_decoded = 1'b1;
        tick();
        hz.i_halt_decoded = 1'b0;
        tick();
        chk("mid_drain_state", 32'(hz.o_state), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_drain_ena", 32'(ena()), 32'(E_OFF));
        chk("rst_drain_state", 32'(hz.o_state), 32'd0);
        tick();
        chk("rst_next_state", 32'(hz.o_state), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ena", 32'(ena()), 32'(E_RUN));
        chk("rst_release_cnt", 32'(hz.o_stall_count), 32'd0);

        // Saturation: 2^16 + 5 stall cycles.
        set_load_use();
        for (int i = 0; i < 65541; i++) begin
            tick();
        end
        chk("sat_cnt", 32'(hz.o_stall_count), 32'h0000_FFFF);
        chk("sat_ena", 32'(ena()), 32'(E_STALL));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
